// File: rtl/dmem_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// dmem_pkg: shared size codes, error codes and state encoding. Rev 1.0
// ------------------------------------------------------------------
package dmem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;
  localparam logic [1:0] SZ_BAD  = 2'd3;

  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_MISALIGN = 2'd1;
  localparam logic [1:0] ERR_CONFLICT = 2'd2;
  localparam logic [1:0] ERR_SIZE     = 2'd3;

  typedef enum logic [0:0] {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage
`default_nettype wire

// File: rtl/dmem_lane_align.sv
`default_nettype none
// ------------------------------------------------------------------
// dmem_lane_align: store lane enables/replication, load extraction. Rev 1.0
// ------------------------------------------------------------------
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic        sign_ext,
  input  logic [31:0] wr_data,
  input  logic [31:0] rd_word,
  output logic [3:0]  byte_en,
  output logic [31:0] wr_lanes,
  output logic [31:0] rd_result
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  always_comb begin
    sel_byte = rd_word[7:0];
    case (addr_lo)
      2'd0:    sel_byte = rd_word[7:0];
      2'd1:    sel_byte = rd_word[15:8];
      2'd2:    sel_byte = rd_word[23:16];
      default: sel_byte = rd_word[31:24];
    endcase
    sel_half = addr_lo[1] ? rd_word[31:16] : rd_word[15:0];
  end

  // Store data is replicated across lanes so the byte enables alone pick the target.
  always_comb begin
    byte_en   = 4'b0000;
    wr_lanes  = wr_data;
    rd_result = rd_word;
    case (size)
      SZ_BYTE: begin
        byte_en   = 4'b0001 << addr_lo;
        wr_lanes  = {4{wr_data[7:0]}};
        rd_result = {{24{sign_ext & sel_byte[7]}}, sel_byte};
      end
      SZ_HALF: begin
        byte_en   = addr_lo[1] ? 4'b1100 : 4'b0011;
        wr_lanes  = {2{wr_data[15:0]}};
        rd_result = {{16{sign_ext & sel_half[15]}}, sel_half};
      end
      SZ_WORD: begin
        byte_en   = 4'b1111;
        wr_lanes  = wr_data;
        rd_result = rd_word;
      end
      default: begin
        byte_en   = 4'b0000;
        wr_lanes  = wr_data;
        rd_result = rd_word;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/dmem_sized.sv
`default_nettype none
// ------------------------------------------------------------------
// dmem_sized: sized byte-lane data memory; DMEM_CLEAR_EN zero-fills on INIT. Rev 1.0
// ------------------------------------------------------------------
module dmem_sized
  import dmem_pkg::*;
#(
  parameter int DEPTH = 128,
  localparam int ADDR_W = $clog2(DEPTH) + 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_wr,
  input  logic              mem_rd,
  input  logic [ADDR_W-1:0] addr,
  input  logic [1:0]        size,
  input  logic              sign_ext,
  input  logic [31:0]       wr_data,
  output logic              ready,
  output logic [31:0]       read_data,
  output logic              rd_valid,
  output logic              err,
  output logic [1:0]        err_code
);

  localparam int WORD_W = ADDR_W - 2;

  state_t state, state_n;

  logic [WORD_W-1:0] word_idx;
  logic              req, misaligned, accept, do_write, do_read;
  logic [1:0]        req_code;
  logic [3:0]        lane_be, mem_be;
  logic [31:0]       lane_wdata, mem_wdata, rd_word, rd_result;
  logic [WORD_W-1:0] mem_widx;
  logic              mem_we;

  assign word_idx = addr[ADDR_W-1:2];
  assign ready    = (state == RUN);

`ifdef DMEM_CLEAR_EN
  localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(DEPTH - 1);
  logic [WORD_W-1:0] init_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      init_cnt <= '0;
    else if (state == INIT)
      init_cnt <= init_cnt + 1'b1;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= INIT;
    else
      state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
`ifdef DMEM_CLEAR_EN
      INIT:    if (init_cnt == LAST_WORD) state_n = RUN;
`else
      INIT:    state_n = RUN;
`endif
      RUN:     state_n = RUN;
      default: state_n = INIT;
    endcase
  end

  assign req        = ready && (mem_wr || mem_rd);
  assign misaligned = ((size == SZ_HALF) && addr[0]) ||
                      ((size == SZ_WORD) && (addr[1:0] != 2'b00));

  always_comb begin
    req_code = ERR_NONE;
    if (mem_wr && mem_rd)
      req_code = ERR_CONFLICT;
    else if (size == SZ_BAD)
      req_code = ERR_SIZE;
    else if (misaligned)
      req_code = ERR_MISALIGN;
  end

  assign accept   = req && (req_code == ERR_NONE);
  assign do_write = accept && mem_wr;
  assign do_read  = accept && mem_rd;

  dmem_lane_align u_lane_align (
    .size      (size),
    .addr_lo   (addr[1:0]),
    .sign_ext  (sign_ext),
    .wr_data   (wr_data),
    .rd_word   (rd_word),
    .byte_en   (lane_be),
    .wr_lanes  (lane_wdata),
    .rd_result (rd_result)
  );

`ifdef DMEM_CLEAR_EN
  always_comb begin
    mem_we    = do_write;
    mem_be    = lane_be;
    mem_widx  = word_idx;
    mem_wdata = lane_wdata;
    if (state == INIT) begin
      mem_we    = 1'b1;
      mem_be    = 4'b1111;
      mem_widx  = init_cnt;
      mem_wdata = '0;
    end
  end
`else
  assign mem_we    = do_write;
  assign mem_be    = lane_be;
  assign mem_widx  = word_idx;
  assign mem_wdata = lane_wdata;
`endif

  // Writes land at the request edge, so a load one cycle later sees the new data.
  for (genvar k = 0; k < 4; k++) begin : g_lane
    logic [7:0] bank [DEPTH];

    always_ff @(posedge clk) begin
      if (mem_we && mem_be[k])
        bank[mem_widx] <= mem_wdata[8*k +: 8];
    end

    assign rd_word[8*k +: 8] = bank[word_idx];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_valid  <= 1'b0;
      err       <= 1'b0;
      err_code  <= ERR_NONE;
      read_data <= '0;
    end else begin
      rd_valid <= do_read;
      err      <= req && (req_code != ERR_NONE);
      err_code <= req ? req_code : ERR_NONE;
      if (do_read)
        read_data <= rd_result;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dmem_sized.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_dmem_sized: directed self-checking bench for dmem_sized. Rev 1.0
// ------------------------------------------------------------------
module tb_dmem_sized;

  localparam int DEPTH  = 128;
  localparam int ADDR_W = $clog2(DEPTH) + 2;
`ifdef DMEM_CLEAR_EN
  localparam int INIT_CYCLES = DEPTH;
`else
  localparam int INIT_CYCLES = 1;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              mem_wr, mem_rd, sign_ext;
  logic [ADDR_W-1:0] addr;
  logic [1:0]        size;
  logic [31:0]       wr_data;
  logic              ready, rd_valid, err;
  logic [31:0]       read_data;
  logic [1:0]        err_code;

  int checks = 0;
  int errors = 0;

  dmem_sized #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .mem_wr    (mem_wr),
    .mem_rd    (mem_rd),
    .addr      (addr),
    .size      (size),
    .sign_ext  (sign_ext),
    .wr_data   (wr_data),
    .ready     (ready),
    .read_data (read_data),
    .rd_valid  (rd_valid),
    .err       (err),
    .err_code  (err_code)
  );

  always #5 clk = ~clk;

  task automatic do_req(input logic wr, input logic rd, input logic [ADDR_W-1:0] a,
                        input logic [1:0] sz, input logic sx, input logic [31:0] d);
    @(negedge clk);
    mem_wr = wr; mem_rd = rd; addr = a; size = sz; sign_ext = sx; wr_data = d;
    @(posedge clk);
    #1;
    mem_wr = 1'b0; mem_rd = 1'b0;
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    for (int i = 0; i < 1000; i++) begin
      @(posedge clk);
      #1;
      n = n + 1;
      if (ready) break;
    end
  endtask

  task automatic test_reset;
    int n;
    rst = 1'b1; mem_wr = 0; mem_rd = 0; addr = '0; size = 2'd0; sign_ext = 0; wr_data = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL rst_ready: got %b want 0", ready); end
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL rst_rd_valid: got %b want 0", rd_valid); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL rst_err: got %b want 0", err); end
    checks++; if (err_code !== 2'd0) begin errors++; $display("FAIL rst_err_code: got %0d want 0", err_code); end
    checks++; if (read_data !== 32'h0) begin errors++; $display("FAIL rst_read_data: got %h want 0", read_data); end
    @(negedge clk);
    rst = 1'b0;
    wait_ready(n);
    checks++; if (n !== INIT_CYCLES) begin errors++; $display("FAIL init_cycles: got %0d want %0d", n, INIT_CYCLES); end
  endtask

  task automatic test_word;
    do_req(1, 0, 9'h010, 2'd2, 0, 32'hDEADBEEF);
    checks++; if (rd_valid !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL store_word_flags: got rd_valid=%b err=%b want 0 0", rd_valid, err); end
    do_req(0, 1, 9'h010, 2'd2, 0, 32'h0);
    checks++; if (rd_valid !== 1'b1) begin errors++; $display("FAIL load_word_valid: got %b want 1", rd_valid); end
    checks++; if (read_data !== 32'hDEADBEEF) begin errors++; $display("FAIL load_word: got %h want deadbeef", read_data); end
    @(posedge clk); #1;
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL rd_valid_pulse: got %b want 0", rd_valid); end
    checks++; if (read_data !== 32'hDEADBEEF) begin errors++; $display("FAIL read_data_hold: got %h want deadbeef", read_data); end
  endtask

  task automatic test_load_ext;
    do_req(0, 1, 9'h013, 2'd0, 1, 32'h0);
    checks++; if (read_data !== 32'hFFFFFFDE) begin errors++; $display("FAIL lb_sext: got %h want ffffffde", read_data); end
    do_req(0, 1, 9'h013, 2'd0, 0, 32'h0);
    checks++; if (read_data !== 32'h000000DE) begin errors++; $display("FAIL lb_zext: got %h want 000000de", read_data); end
    do_req(0, 1, 9'h012, 2'd1, 1, 32'h0);
    checks++; if (read_data !== 32'hFFFFDEAD) begin errors++; $display("FAIL lh_sext: got %h want ffffdead", read_data); end
    do_req(0, 1, 9'h011, 2'd0, 1, 32'h0);
    checks++; if (read_data !== 32'hFFFFFFBE) begin errors++; $display("FAIL lb1_sext: got %h want ffffffbe", read_data); end
  endtask

  task automatic test_narrow_store;
    do_req(1, 0, 9'h011, 2'd0, 0, 32'hAAAAAA55);
    do_req(0, 1, 9'h010, 2'd2, 0, 32'h0);
    checks++; if (read_data !== 32'hDEAD55EF) begin errors++; $display("FAIL sb_merge: got %h want dead55ef", read_data); end
    do_req(1, 0, 9'h012, 2'd1, 0, 32'h1234CAFE);
    do_req(0, 1, 9'h010, 2'd2, 0, 32'h0);
    checks++; if (read_data !== 32'hCAFE55EF) begin errors++; $display("FAIL sh_merge: got %h want cafe55ef", read_data); end
    do_req(0, 1, 9'h010, 2'd1, 0, 32'h0);
    checks++; if (read_data !== 32'h000055EF) begin errors++; $display("FAIL lh_zext: got %h want 000055ef", read_data); end
  endtask

  task automatic test_errors;
    do_req(0, 1, 9'h012, 2'd2, 0, 32'h0);
    checks++; if (err !== 1'b1 || err_code !== 2'd1 || rd_valid !== 1'b0) begin errors++; $display("FAIL misalign_lw: got err=%b code=%0d rd_valid=%b want 1 1 0", err, err_code, rd_valid); end
    @(posedge clk); #1;
    checks++; if (err !== 1'b0 || err_code !== 2'd0) begin errors++; $display("FAIL err_pulse: got err=%b code=%0d want 0 0", err, err_code); end
    do_req(1, 1, 9'h010, 2'd2, 0, 32'h00000000);
    checks++; if (err !== 1'b1 || err_code !== 2'd2 || rd_valid !== 1'b0) begin errors++; $display("FAIL conflict: got err=%b code=%0d rd_valid=%b want 1 2 0", err, err_code, rd_valid); end
    do_req(1, 1, 9'h011, 2'd3, 0, 32'h0);
    checks++; if (err_code !== 2'd2) begin errors++; $display("FAIL prio_conflict: got %0d want 2", err_code); end
    do_req(0, 1, 9'h011, 2'd3, 0, 32'h0);
    checks++; if (err !== 1'b1 || err_code !== 2'd3) begin errors++; $display("FAIL bad_size: got err=%b code=%0d want 1 3", err, err_code); end
    do_req(1, 0, 9'h010, 2'd3, 0, 32'h11111111);
    checks++; if (err_code !== 2'd3) begin errors++; $display("FAIL bad_size_store: got %0d want 3", err_code); end
    do_req(1, 0, 9'h011, 2'd1, 0, 32'h22222222);
    checks++; if (err_code !== 2'd1) begin errors++; $display("FAIL misalign_sh: got %0d want 1", err_code); end
    do_req(0, 1, 9'h010, 2'd2, 0, 32'h0);
    checks++; if (read_data !== 32'hCAFE55EF || err !== 1'b0) begin errors++; $display("FAIL err_no_write: got %h err=%b want cafe55ef 0", read_data, err); end
  endtask

  task automatic test_back_to_back;
    do_req(1, 0, 9'h020, 2'd2, 0, 32'h12345678);
    do_req(0, 1, 9'h020, 2'd2, 0, 32'h0);
    checks++; if (read_data !== 32'h12345678 || rd_valid !== 1'b1) begin errors++; $display("FAIL b2b_word: got %h v=%b want 12345678 1", read_data, rd_valid); end
    do_req(1, 0, 9'h023, 2'd0, 0, 32'h000000A5);
    do_req(0, 1, 9'h020, 2'd2, 0, 32'h0);
    checks++; if (read_data !== 32'hA5345678) begin errors++; $display("FAIL b2b_byte: got %h want a5345678", read_data); end
  endtask

  task automatic test_rst_after_load;
    int n;
    @(negedge clk);
    mem_rd = 1'b1; addr = 9'h010; size = 2'd2; sign_ext = 1'b0;
    #2 rst = 1'b1;
    #1;
    checks++; if (read_data !== 32'h0 || rd_valid !== 1'b0 || ready !== 1'b0) begin errors++; $display("FAIL async_rst: got data=%h v=%b rdy=%b want 0 0 0", read_data, rd_valid, ready); end
    @(posedge clk); #1;
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL rst_no_valid: got %b want 0", rd_valid); end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    checks++; if (rd_valid !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL init_ignore: got v=%b err=%b want 0 0", rd_valid, err); end
    checks++; if (ready !== (INIT_CYCLES == 1)) begin errors++; $display("FAIL ready_after_1: got %b want %b", ready, INIT_CYCLES == 1); end
    mem_rd = 1'b0;
    if (!ready) begin
      wait_ready(n);
      checks++; if (n !== INIT_CYCLES - 1) begin errors++; $display("FAIL ready_rest: got %0d want %0d", n, INIT_CYCLES - 1); end
    end
  endtask

`ifdef DMEM_CLEAR_EN
  task automatic test_clear;
    int n;
    do_req(1, 0, 9'h1FC, 2'd2, 0, 32'hFFFFFFFF);
    do_req(1, 0, 9'h010, 2'd2, 0, 32'h5A5A5A5A);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    repeat (50) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    wait_ready(n);
    checks++; if (n !== DEPTH) begin errors++; $display("FAIL clear_restart: got %0d want %0d", n, DEPTH); end
    do_req(0, 1, 9'h010, 2'd2, 0, 32'h0);
    checks++; if (read_data !== 32'h0 || rd_valid !== 1'b1) begin errors++; $display("FAIL clear_word10: got %h v=%b want 0 1", read_data, rd_valid); end
    do_req(0, 1, 9'h1FC, 2'd2, 0, 32'h0);
    checks++; if (read_data !== 32'h0) begin errors++; $display("FAIL clear_last: got %h want 0", read_data); end
  endtask
`endif

  initial begin
    test_reset();
    test_word();
    test_load_ext();
    test_narrow_store();
    test_errors();
    test_back_to_back();
    test_rst_after_load();
`ifdef DMEM_CLEAR_EN
    test_clear();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
